mul_sequencer: RTL and testbench

- Iterative shift-add controller for the LEGv8 MUL instruction in the execute stage.
- Accepts two 64-bit operands on a start pulse and sequences N add/shift iterations on an internal accumulator.
- Stalls the pipeline while running, then presents the low N bits of the product with a one-cycle done pulse.
- Sits beside the ALU in execute; its result is muxed into aluResult_E by the enclosing stage when done_E is high.

---
 rtl/mul_sequencer.sv | 127 ++++++++++++
 tb/tb_mul_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier sequencer for the LEGv8 MUL instruction (execute stage).
// Optional macro MUL_SEQ_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module mul_sequencer #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_E,
    input  logic [N-1:0] opA_E,
    input  logic [N-1:0] opB_E,
    output logic         stall_E,
    output logic         busy_E,
    output logic         done_E,
    output logic [N-1:0] result_E
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [N-1:0]   acc_r;
    logic [N-1:0]   mcand_r;
    logic [N-1:0]   mplier_r;
    logic [CW-1:0]  count_r;
    logic [N-1:0]   acc_next_s;
    logic [N-1:0]   mplier_shift_s;
    logic           last_iter_s;

    // One shift-add iteration and the decision whether it is the final one.
    always_comb begin
        acc_next_s     = acc_r;
        mplier_shift_s = mplier_r >> 1;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
`ifdef MUL_SEQ_EARLY_TERM_EN
        last_iter_s = (count_r == CW'(N - 1)) || (mplier_shift_s == {N{1'b0}});
`else
        last_iter_s = (count_r == CW'(N - 1));
`endif
    end

    // Next-state logic and the combinational pipeline stall.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_E) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_iter_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
        // In DONE the stall drops so the instruction advances together with its result.
        stall_E = (state_r == RUN) || ((state_r == IDLE) && start_E)
                  || ((state_r == DONE) && !done_E);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r    <= {N{1'b0}};
            mcand_r  <= {N{1'b0}};
            mplier_r <= {N{1'b0}};
            count_r  <= {CW{1'b0}};
            result_E <= {N{1'b0}};
            busy_E   <= 1'b0;
            done_E   <= 1'b0;
        end else begin
            busy_E <= (state_s == RUN);
            done_E <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start_E) begin
                        acc_r    <= {N{1'b0}};
                        mcand_r  <= opA_E;
                        mplier_r <= opB_E;
                        count_r  <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_shift_s;
                    count_r  <= count_r + CW'(1);
                    if (last_iter_s) begin
                        result_E <= acc_next_s;
                    end
                end
                DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= {N{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: random operands against a plain-arithmetic product/latency model.
module tb_mul_sequencer;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_E;
    logic [N-1:0] opA_E;
    logic [N-1:0] opB_E;
    logic         stall_E;
    logic         busy_E;
    logic         done_E;
    logic [N-1:0] result_E;

    int pass_cnt = 0;
    int total_cnt = 0;

    mul_sequencer #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_E  (start_E),
        .opA_E    (opA_E),
        .opB_E    (opB_E),
        .stall_E  (stall_E),
        .busy_E   (busy_E),
        .done_E   (done_E),
        .result_E (result_E)
    );

    always #5 clk = ~clk;

    // Reference: number of RUN cycles for a given multiplier.
    function automatic int exp_run(input logic [N-1:0] b);
`ifdef MUL_SEQ_EARLY_TERM_EN
        int h = 1;
        for (int i = 0; i < N; i++) if (b[i]) h = i + 1;
        return h;
`else
        return N;
`endif
    endfunction

    function automatic logic [N-1:0] exp_prod(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] p;
        p = a * b;
        return p;
    endfunction

    // Stimulus driver: issues one multiply and observes it; cyc is the cycle offset of done_E from the accept edge.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit noise,
                          output int cyc, output int busy_n, output int stall_bad,
                          output bit stall_start, output bit stall_done, output bit done_after,
                          output bit got, output logic [N-1:0] res);
        @(negedge clk);
        opA_E = a; opB_E = b; start_E = 1'b1;
        #1 stall_start = stall_E;
        @(posedge clk);
        #1 start_E = 1'b0;
        cyc = 0; busy_n = 0; stall_bad = 0; got = 1'b0;
        stall_done = 1'b1; done_after = 1'b1; res = '0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (busy_E) busy_n++;
            if (done_E) begin
                got = 1'b1;
                res = result_E;
                stall_done = stall_E;
                start_E = 1'b0;
            end else begin
                if (stall_E !== 1'b1) stall_bad++;
                if (noise) begin
                    opA_E = {$urandom, $urandom};
                    opB_E = {$urandom, $urandom};
                    start_E = 1'($urandom_range(0, 1));
                end
            end
        end
        start_E = 1'b0;
        if (got) begin
            @(negedge clk);
            done_after = done_E;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start_E = 1'b0; opA_E = '0; opB_E = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if (busy_E !== 1'b0) $display("FAIL reset_busy cyc=%0d got=%b exp=0", i, busy_E); else pass_cnt++;
            total_cnt++;
            if (done_E !== 1'b0) $display("FAIL reset_done cyc=%0d got=%b exp=0", i, done_E); else pass_cnt++;
            total_cnt++;
            if (result_E !== '0) $display("FAIL reset_result cyc=%0d got=%h exp=0", i, result_E); else pass_cnt++;
            total_cnt++;
            if (stall_E !== 1'b0) $display("FAIL reset_stall cyc=%0d got=%b exp=0", i, stall_E); else pass_cnt++;
        end
    endtask

    task automatic test_basic;
        int cyc, busy_n, stall_bad;
        bit ss, sd, da, got;
        logic [N-1:0] res;
        run_op(64'd7, 64'd6, 1'b0, cyc, busy_n, stall_bad, ss, sd, da, got, res);
        total_cnt++;
        if (ss !== 1'b1) $display("FAIL basic_stall_start got=%b exp=1", ss); else pass_cnt++;
        total_cnt++;
        if (busy_n != exp_run(64'd6)) $display("FAIL basic_busy_cycles got=%0d exp=%0d", busy_n, exp_run(64'd6)); else pass_cnt++;
        total_cnt++;
        if (stall_bad != 0) $display("FAIL basic_stall_run bad_cycles=%0d exp=0", stall_bad); else pass_cnt++;
        total_cnt++;
        if (!got || cyc != exp_run(64'd6) + 1) $display("FAIL basic_latency got=%0d exp=%0d", cyc, exp_run(64'd6) + 1); else pass_cnt++;
        total_cnt++;
        if (res !== 64'd42) $display("FAIL basic_result got=%0d exp=42", res); else pass_cnt++;
        total_cnt++;
        if (sd !== 1'b0) $display("FAIL basic_stall_done got=%b exp=0", sd); else pass_cnt++;
        total_cnt++;
        if (da !== 1'b0) $display("FAIL basic_done_width got=%b exp=0", da); else pass_cnt++;
    endtask

    task automatic test_wrap;
        logic [N-1:0] a_tab [2];
        logic [N-1:0] b_tab [2];
        logic [N-1:0] e_tab [2];
        int cyc, busy_n, stall_bad;
        bit ss, sd, da, got;
        logic [N-1:0] res;
        a_tab[0] = 64'hFFFF_FFFF_FFFF_FFFF; b_tab[0] = 64'hFFFF_FFFF_FFFF_FFFF; e_tab[0] = 64'd1;
        a_tab[1] = 64'h8000_0000_0000_0000; b_tab[1] = 64'd2;                   e_tab[1] = 64'd0;
        for (int i = 0; i < 2; i++) begin
            run_op(a_tab[i], b_tab[i], 1'b0, cyc, busy_n, stall_bad, ss, sd, da, got, res);
            total_cnt++;
            if (res !== e_tab[i]) $display("FAIL wrap_result case=%0d got=%h exp=%h", i, res, e_tab[i]); else pass_cnt++;
            total_cnt++;
            if (!got || cyc != exp_run(b_tab[i]) + 1) $display("FAIL wrap_latency case=%0d got=%0d exp=%0d", i, cyc, exp_run(b_tab[i]) + 1); else pass_cnt++;
        end
    endtask

    task automatic test_random;
        int cyc, busy_n, stall_bad;
        bit ss, sd, da, got;
        logic [N-1:0] res, a, b;
        for (int i = 0; i < 10; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            run_op(a, b, 1'b1, cyc, busy_n, stall_bad, ss, sd, da, got, res);
            total_cnt++;
            if (res !== exp_prod(a, b)) $display("FAIL rand_result i=%0d got=%h exp=%h", i, res, exp_prod(a, b)); else pass_cnt++;
            total_cnt++;
            if (!got || cyc != exp_run(b) + 1) $display("FAIL rand_latency i=%0d got=%0d exp=%0d", i, cyc, exp_run(b) + 1); else pass_cnt++;
            total_cnt++;
            if (stall_bad != 0 || da !== 1'b0) $display("FAIL rand_stall_done i=%0d stall_bad=%0d done_after=%b exp=0/0", i, stall_bad, da); else pass_cnt++;
        end
    endtask

    task automatic test_abort;
        int pulses, cyc, busy_n, stall_bad;
        bit ss, sd, da, got;
        logic [N-1:0] res;
        @(negedge clk);
        opA_E = 64'd3; opB_E = 64'd5; start_E = 1'b1;
        @(posedge clk);
        #1 start_E = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy_E !== 1'b0 || done_E !== 1'b0 || stall_E !== 1'b0)
            $display("FAIL abort_idle busy=%b done=%b stall=%b exp=0/0/0", busy_E, done_E, stall_E);
        else pass_cnt++;
        total_cnt++;
        if (result_E !== '0) $display("FAIL abort_result got=%h exp=0", result_E); else pass_cnt++;
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done_E) pulses++;
        end
        total_cnt++;
        if (pulses != 0) $display("FAIL abort_no_done got=%0d exp=0", pulses); else pass_cnt++;
        run_op(64'd3, 64'd5, 1'b0, cyc, busy_n, stall_bad, ss, sd, da, got, res);
        total_cnt++;
        if (res !== 64'd15) $display("FAIL abort_restart got=%0d exp=15", res); else pass_cnt++;
    endtask

    task automatic test_reset_start;
        @(negedge clk);
        reset = 1'b1; start_E = 1'b1; opA_E = 64'd11; opB_E = 64'd13;
        @(posedge clk);
        #1 reset = 1'b0; start_E = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy_E !== 1'b0 || result_E !== '0) $display("FAIL reset_start busy=%b result=%h exp=0/0", busy_E, result_E); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int exp_done [$];
        int got_done [$];
        int lat, c;
        bit bad_res;
        lat = exp_run(64'd4);
        for (int t = 0; t <= 69; t += lat + 2) exp_done.push_back(t + lat + 1);
        @(negedge clk);
        opA_E = 64'd4; opB_E = 64'd4; start_E = 1'b1;
        @(posedge clk);
        bad_res = 1'b0;
        for (c = 1; c <= 220; c++) begin
            @(negedge clk);
            if (done_E) begin
                got_done.push_back(c);
                if (result_E !== 64'd16) bad_res = 1'b1;
            end
            start_E = (c <= 69);
        end
        start_E = 1'b0;
        total_cnt++;
        if (got_done.size() != exp_done.size()) $display("FAIL b2b_count got=%0d exp=%0d", got_done.size(), exp_done.size()); else pass_cnt++;
        for (int i = 0; i < exp_done.size() && i < got_done.size(); i++) begin
            total_cnt++;
            if (got_done[i] != exp_done[i]) $display("FAIL b2b_done_time idx=%0d got=%0d exp=%0d", i, got_done[i], exp_done[i]); else pass_cnt++;
        end
        total_cnt++;
        if (bad_res) $display("FAIL b2b_result got=non16 exp=16"); else pass_cnt++;
    endtask

    task automatic test_early_term;
        logic [N-1:0] b_tab [2];
        int cyc, busy_n, stall_bad;
        bit ss, sd, da, got;
        logic [N-1:0] res;
        b_tab[0] = 64'd0;
        b_tab[1] = 64'd5;
        for (int i = 0; i < 2; i++) begin
            run_op(64'd9, b_tab[i], 1'b0, cyc, busy_n, stall_bad, ss, sd, da, got, res);
            total_cnt++;
            if (!got || cyc != exp_run(b_tab[i]) + 1) $display("FAIL early_latency case=%0d got=%0d exp=%0d", i, cyc, exp_run(b_tab[i]) + 1); else pass_cnt++;
            total_cnt++;
            if (res !== exp_prod(64'd9, b_tab[i])) $display("FAIL early_result case=%0d got=%0d exp=%0d", i, res, exp_prod(64'd9, b_tab[i])); else pass_cnt++;
        end
    endtask

    initial begin
        reset = 1'b1; start_E = 1'b0; opA_E = '0; opB_E = '0;
        repeat (3) @(posedge clk);
        test_reset;
        test_basic;
        test_wrap;
        test_random;
        test_abort;
        test_reset_start;
        test_back_to_back;
        test_early_term;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
